priority_1_driver: RTL

Command-driven transmitter for the `do`/`sel`/`f` handshake of the priority_1 FSM: it generates the `do` and `sel` stimulus that walks the peer FSM IDLE→RUN→MIDDLE→exit. It checks the peer's registered `f` pulse against the requested exit and reports one status per command. It sits on the initiator side of the peer, fed by a sequencer or bus-mapped control register.

---
 rtl/priority_pkg.sv | 35 +++
 rtl/priority_drv_timer.sv | 25 ++
 rtl/priority_1_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/priority_pkg.sv
// Shared encodings for the priority_1 peer handshake and its command-driven driver.
package priority_pkg;

    typedef enum logic [1:0] {
        PEER_IDLE   = 2'd0,
        PEER_RUN    = 2'd1,
        PEER_LAST   = 2'd2,
        PEER_MIDDLE = 2'd3
    } peer_state_e;

    localparam logic [1:0] SEL_TO_IDLE = 2'd2;
    localparam logic [1:0] SEL_TO_LAST = 2'd3;

    typedef enum logic [1:0] {
        RSP_OK_LAST      = 2'd0,
        RSP_OK_IDLE      = 2'd1,
        RSP_TIMEOUT      = 2'd2,
        RSP_UNEXPECTED_F = 2'd3
    } rsp_status_e;

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_DRIVE,
        DRV_WATCH,
        DRV_PARK,
        DRV_RECOVER,
        DRV_RESP
    } drv_state_e;

    // Timer counts down to zero, so an L-cycle phase loads L-1; zero length runs one cycle.
    function automatic logic [3:0] len_to_load(input logic [3:0] len);
        return (len == 4'd0) ? 4'd0 : len - 4'd1;
    endfunction

endpackage

// File: rtl/priority_drv_timer.sv
// Loadable 4-bit down-counter; holds at zero so it never wraps.
module priority_drv_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       expired_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/priority_1_driver.sv
// Command-driven do/sel transmitter for the priority_1 peer; reports one status per command.
module priority_1_driver
    import priority_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [3:0] cmd_len_i,
    input  logic [1:0] cmd_exit_i,
    output logic       do_o,
    output logic [1:0] sel_o,
    input  logic       f_i,
    output logic       rsp_valid_o,
    output logic [1:0] rsp_status_o,
    output logic [7:0] f_cnt_o
);

    if (TIMEOUT < 3 || TIMEOUT > 15) begin : g_bad_timeout
        $error("priority_1_driver: TIMEOUT must be in 3..15");
    end

    localparam logic [3:0] WIN_LOAD = 4'(TIMEOUT - 1);

    drv_state_e  state_q, state_d;
    rsp_status_e status_q, status_d;
    logic [1:0]  exit_q, exit_d;
    logic        do_q, do_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  f_cnt_q;
    logic        tmr_load, tmr_en, tmr_expired;
    logic [3:0]  tmr_val;

    priority_drv_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        exit_d   = exit_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state_q)
            DRV_IDLE: begin
                if (cmd_valid_i) begin
                    exit_d   = cmd_exit_i;
                    tmr_load = 1'b1;
                    tmr_val  = len_to_load(cmd_len_i);
                    state_d  = DRV_DRIVE;
                end
            end
            DRV_DRIVE: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_LOAD;
                    // exit codes 0/1 leave the peer parked in MIDDLE
                    state_d  = exit_q[1] ? DRV_WATCH : DRV_PARK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DRV_WATCH: begin
                if (f_i) begin
                    state_d  = DRV_RESP;
                    status_d = (exit_q == SEL_TO_LAST) ? RSP_OK_LAST : RSP_UNEXPECTED_F;
                end else if (tmr_expired) begin
                    state_d  = DRV_RESP;
                    status_d = (exit_q == SEL_TO_LAST) ? RSP_TIMEOUT : RSP_OK_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DRV_PARK: begin
                if (f_i) begin
                    state_d  = DRV_RESP;
                    status_d = RSP_UNEXPECTED_F;
                end else if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = 4'd1;
                    state_d  = DRV_RECOVER;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DRV_RECOVER: begin
                if (f_i) begin
                    state_d  = DRV_RESP;
                    status_d = RSP_UNEXPECTED_F;
                end else if (tmr_expired) begin
                    state_d  = DRV_RESP;
                    status_d = RSP_OK_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DRV_RESP: state_d = DRV_IDLE;
            default:  state_d = DRV_IDLE;
        endcase

        do_d  = (state_d == DRV_DRIVE);
        sel_d = '0;
        case (state_d)
            DRV_WATCH, DRV_PARK: sel_d = exit_q;
            DRV_RECOVER:         sel_d = SEL_TO_IDLE;
            default:             sel_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DRV_IDLE;
            status_q <= RSP_OK_LAST;
            exit_q   <= '0;
            do_q     <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            exit_q   <= exit_d;
            do_q     <= do_d;
            sel_q    <= sel_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt_q <= '0;
        end else if (f_i && (f_cnt_q != 8'hFF)) begin
            f_cnt_q <= f_cnt_q + 8'd1;
        end
    end

    assign cmd_ready_o  = (state_q == DRV_IDLE);
    assign rsp_valid_o  = (state_q == DRV_RESP);
    assign rsp_status_o = status_q;
    assign do_o         = do_q;
    assign sel_o        = sel_q;
    assign f_cnt_o      = f_cnt_q;

endmodule
